// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// to instruction memory port 0, then releases the core PC from reset.
module imem_boot_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              we0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [31:0]       wr_din0,
  output logic              resetpc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  state_t            state_q;
  logic [7:0]        len_q;
  logic [IW-1:0]     word_idx_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       pack_q;
  logic              s_ready_q, we0_q, resetpc_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_din_q;

  logic len_ok_d, last_word_d;
  assign len_ok_d    = (len_words != 8'd0) && (32'(len_words) <= 32'(MAX_WORDS));
  assign last_word_d = (8'(word_idx_q) == (len_q - 8'd1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      s_ready_q  <= 1'b0;
      we0_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_din_q   <= '0;
      resetpc_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      we0_q <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            if (len_ok_d) begin
              state_q    <= LOAD;
              len_q      <= len_words;
              word_idx_q <= '0;
              byte_cnt_q <= '0;
              pack_q     <= '0;
              s_ready_q  <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              resetpc_q  <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (start) err_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: pack_q[7:0]   <= s_data;
              2'd1: pack_q[15:8]  <= s_data;
              2'd2: pack_q[23:16] <= s_data;
              default: begin
                // 4th byte goes straight to the write bus; ready drops with it
                state_q   <= WRITE;
                s_ready_q <= 1'b0;
                we0_q     <= 1'b1;
                wr_addr_q <= ADDR_W'({word_idx_q, 2'b00});
                wr_din_q  <= {s_data, pack_q};
              end
            endcase
          end
        end
        WRITE: begin
          if (start) err_q <= 1'b1;
          if (last_word_d) begin
            state_q   <= RUN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            resetpc_q <= 1'b1;
          end else begin
            state_q    <= LOAD;
            word_idx_q <= word_idx_q + 1'b1;
            byte_cnt_q <= '0;
            s_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign we0      = we0_q;
  assign wr_addr0 = wr_addr_q;
  assign wr_din0  = wr_din_q;
  assign resetpc  = resetpc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: inputs change and outputs are sampled on negedge.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        reset, start, s_valid;
  logic [7:0]  len_words, s_data;
  logic        s_ready, we0, resetpc, busy, done, err;
  logic [8:0]  wr_addr0;
  logic [31:0] wr_din0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bq[$];
  logic [8:0]  wa[$];
  logic [31:0] wd[$];
  int          rdy_in_wr = 0;

  imem_boot_loader #(.ADDR_W(9), .MAX_WORDS(128)) dut (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we0(we0),
    .wr_addr0(wr_addr0), .wr_din0(wr_din0), .resetpc(resetpc), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      wa.push_back(wr_addr0);
      wd.push_back(wr_din0);
      if (s_ready !== 1'b0) rdy_in_wr++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1; len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds bq; returns at the negedge after the edge that accepted the last byte
  // (toggle mode adds one idle cycle after every accepted byte).
  task automatic feed(input bit toggle);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < bq.size() && guard < 5000) begin
      s_valid = 1'b1; s_data = bq[i];
      rdy = s_ready;
      @(negedge clk);
      if (rdy) i++;
      if (toggle) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      guard++;
    end
    s_valid = 1'b0;
    checks++;
    if (i != bq.size()) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d bytes expected %0d", i, bq.size());
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    bq.push_back(w[7:0]);  bq.push_back(w[15:8]);
    bq.push_back(w[23:16]); bq.push_back(w[31:24]);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; s_valid = 1'b1; len_words = 8'd2; s_data = 8'hFF;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {s_ready, we0, wr_addr0, wr_din0, resetpc, busy, done, err}, 64'd0);
    reset = 1'b1; start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {s_ready, busy, resetpc, done, err}, 64'd0);
  endtask

  task automatic test_basic;
    wa.delete(); wd.delete(); bq.delete();
    do_start(8'd2);
    chk("basic_busy_ready", {busy, s_ready, resetpc}, 64'b110);
    bq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    feed(1'b0);
    chk("basic_last_we0", {we0, resetpc, wr_addr0}, {1'b1, 1'b0, 9'd4});
    @(negedge clk);
    chk("basic_run", {resetpc, done, busy, we0}, 64'b1100);
    @(negedge clk);
    chk("basic_nwrites", wa.size(), 2);
    chk("basic_w0", {wa[0], wd[0]}, {9'd0, 32'h00500013});
    chk("basic_w1", {wa[1], wd[1]}, {9'd4, 32'h00100093});
  endtask

  task automatic test_toggle;
    wa.delete(); wd.delete(); bq.delete(); rdy_in_wr = 0;
    do_start(8'd3);
    chk("toggle_reload_pc", resetpc, 1'b0);
    push_word(32'h11223344); push_word(32'hDEADBEEF); push_word(32'h00000001);
    feed(1'b1);
    @(negedge clk);
    chk("toggle_done", {resetpc, done}, 2'b11);
    chk("toggle_nwrites", wa.size(), 3);
    chk("toggle_w0", {wa[0], wd[0]}, {9'd0, 32'h11223344});
    chk("toggle_w1", {wa[1], wd[1]}, {9'd4, 32'hDEADBEEF});
    chk("toggle_w2", {wa[2], wd[2]}, {9'd8, 32'h00000001});
    chk("toggle_ready_in_write", rdy_in_wr, 0);
  endtask

  task automatic test_err;
    reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
    wa.delete(); wd.delete(); bq.delete();
    do_start(8'd0);
    chk("err_len0", {err, busy}, 2'b10);
    @(negedge clk);
    chk("err_pulse_clears", err, 1'b0);
    do_start(8'd129);
    chk("err_len129", {err, busy, resetpc}, 3'b100);
    @(negedge clk);
    chk("err_no_write", wa.size(), 0);
    do_start(8'd1);
    bq = '{8'h78, 8'h56};
    feed(1'b0);
    do_start(8'd5);
    chk("err_while_busy", {err, busy, s_ready}, 3'b111);
    bq = '{8'h34, 8'h12};
    feed(1'b0);
    @(negedge clk); @(negedge clk);
    chk("err_load_completes", {done, resetpc}, 2'b11);
    chk("err_load_word", {9'(wa.size()), wd[0]}, {9'd1, 32'h12345678});
  endtask

  task automatic test_full;
    int bad = 0;
    logic [7:0] b;
    wa.delete(); wd.delete(); bq.delete();
    do_start(8'd128);
    for (int i = 0; i < 128; i++) begin
      b = 8'(i);
      push_word({b, b ^ 8'hA5, 8'h5A, b});
    end
    feed(1'b0);
    @(negedge clk); @(negedge clk);
    chk("full_nwrites", wa.size(), 128);
    for (int i = 0; i < wa.size(); i++) begin
      b = 8'(i);
      if (wa[i] !== 9'(4 * i) || wd[i] !== {b, b ^ 8'hA5, 8'h5A, b}) bad++;
    end
    chk("full_words_bad", bad, 0);
    chk("full_last", {wa[wa.size()-1], wd[wd.size()-1]}, {9'd508, 32'h7FDA5A7F});
    chk("full_run", {resetpc, done}, 2'b11);
    wa.delete(); wd.delete(); bq.delete();
    do_start(8'd1);
    chk("reload_pc_low", {resetpc, done, busy}, 3'b001);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    feed(1'b0);
    @(negedge clk); @(negedge clk);
    chk("reload_write", {9'(wa.size()), wa[0], wd[0]}, {9'd1, 9'd0, 32'hDDCCBBAA});
    chk("reload_pc_high", resetpc, 1'b1);
  endtask

  task automatic test_reset_mid;
    wa.delete(); wd.delete(); bq.delete();
    do_start(8'd2);
    bq = '{8'h01, 8'h02};
    feed(1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_outputs", {s_ready, we0, wr_addr0, wr_din0, resetpc, busy, done, err}, 64'd0);
    repeat (3) @(negedge clk);
    chk("midreset_no_write", {9'(wa.size()), s_ready, busy}, 11'd0);
    do_start(8'd1);
    bq = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    feed(1'b0);
    @(negedge clk); @(negedge clk);
    chk("midreset_fresh_word", {9'(wa.size()), wd[0]}, {9'd1, 32'h89ABCDEF});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; s_valid = 1'b0; len_words = 8'd0; s_data = 8'd0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_toggle;
    test_err;
    test_full;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
